// File: rtl/mdu_hilo_ctrl.sv
// mdu_hilo_ctrl
// Sequencer between the EX stage and the multiply/divide unit (MDU).
// It accepts one MDU-class instruction at a time and latches its operands.
// It drives the MDU control code until the result is available and stalls the
// pipeline while it waits. It then commits the 64-bit result into the
// architectural HI/LO registers.
// MTHI/MTLO are executed directly. An exception flush discards in-flight work
// and inserts one idle-code cycle so the divider can return to rest.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   op_valid_i      EX stage holds an MDU-class instruction
//   op_i[2:0]       0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//   a_i, b_i        rs / rt operands (a_i is the MTHI/MTLO source)
//   flush_i         exception/eret flush of EX and older stages
//   mdu_ctrl_o      control code to the MDU
//   mdu_a_o/b_o     latched operands to the MDU
//   mdu_result_i    MDU result {HI, LO}
//   mdu_ready_i     MDU result valid (level)
//   stall_o         combinational, freeze IF..EX this cycle
//   busy_o          sequencer not idle
//   hi_o, lo_o      architectural HI / LO registers
module mdu_hilo_ctrl #(
    parameter logic [4:0] CODE_NONE  = 5'd0,
    parameter logic [4:0] CODE_MULT  = 5'd1,
    parameter logic [4:0] CODE_MULTU = 5'd2,
    parameter logic [4:0] CODE_DIV   = 5'd3,
    parameter logic [4:0] CODE_DIVU  = 5'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic [4:0]  mdu_ctrl_o,
    output logic [31:0] mdu_a_o,
    output logic [31:0] mdu_b_o,
    input  logic [63:0] mdu_result_i,
    input  logic        mdu_ready_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state;
    state_t      state_next;
    logic [31:0] lat_a;
    logic [31:0] lat_b;
    logic        lat_unsigned;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        issue;
    logic        commit;
    logic        write_hi;
    logic        write_lo;
    logic        stall;

    // Next-state and per-cycle actions. Flush wins over every other event,
    // including a divide result that becomes ready in the same cycle.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        commit     = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (!flush_i && op_valid_i) begin
                    case (op_i)
                        OP_MULT, OP_MULTU: begin
                            issue      = 1'b1;
                            stall      = 1'b1;
                            state_next = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            issue      = 1'b1;
                            stall      = 1'b1;
                            state_next = DIV;
                        end
                        OP_MTHI: write_hi = 1'b1;
                        OP_MTLO: write_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            // The multiplier is combinational, so its result is taken
            // unconditionally one cycle after issue.
            MUL: begin
                if (flush_i) begin
                    state_next = FLUSH;
                end else begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            DIV: begin
                if (flush_i) begin
                    state_next = FLUSH;
                end else if (mdu_ready_i) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, operand latches and HI/LO. The latches only change on issue,
    // so the MDU sees stable operands while a divide is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lat_a        <= 32'd0;
            lat_b        <= 32'd0;
            lat_unsigned <= 1'b0;
            hi           <= 32'd0;
            lo           <= 32'd0;
        end else begin
            state <= state_next;
            if (issue) begin
                lat_a        <= a_i;
                lat_b        <= b_i;
                lat_unsigned <= (op_i == OP_MULTU) || (op_i == OP_DIVU);
            end
            if (commit) begin
                hi <= mdu_result_i[63:32];
                lo <= mdu_result_i[31:0];
            end
            if (write_hi) begin
                hi <= a_i;
            end
            if (write_lo) begin
                lo <= a_i;
            end
        end
    end

    // Control code comes from the registered state only. It is forced idle
    // while reset is held, so the divider is never driven during reset.
    always_comb begin
        mdu_ctrl_o = CODE_NONE;
        if (!rst) begin
            case (state)
                MUL:     mdu_ctrl_o = lat_unsigned ? CODE_MULTU : CODE_MULT;
                DIV:     mdu_ctrl_o = lat_unsigned ? CODE_DIVU : CODE_DIV;
                default: mdu_ctrl_o = CODE_NONE;
            endcase
        end
    end

    assign stall_o = stall & ~rst;
    assign busy_o  = (state != IDLE);
    assign mdu_a_o = lat_a;
    assign mdu_b_o = lat_b;
    assign hi_o    = hi;
    assign lo_o    = lo;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// tb_mdu_hilo_ctrl
// Self-checking bench for mdu_hilo_ctrl. An arithmetic model of the
// multiply/divide unit feeds mdu_result_i. Each instruction is treated as a
// transaction. Its expected HI/LO, stall and busy timeline come from the
// instruction-level rules: multiply stalls once, divide stalls until ready,
// flush discards the result and adds one idle cycle.
// Directed cases are followed by a randomized mix.
module tb_mdu_hilo_ctrl;

    localparam logic [4:0] C_NONE  = 5'd0;
    localparam logic [4:0] C_MULT  = 5'd9;
    localparam logic [4:0] C_MULTU = 5'd10;
    localparam logic [4:0] C_DIV   = 5'd17;
    localparam logic [4:0] C_DIVU  = 5'd18;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic [4:0]  mdu_ctrl;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic [63:0] mdu_result;
    logic        mdu_ready;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_hilo_ctrl #(
        .CODE_NONE (C_NONE),
        .CODE_MULT (C_MULT),
        .CODE_MULTU(C_MULTU),
        .CODE_DIV  (C_DIV),
        .CODE_DIVU (C_DIVU)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid_i  (op_valid),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .flush_i     (flush),
        .mdu_ctrl_o  (mdu_ctrl),
        .mdu_a_o     (mdu_a),
        .mdu_b_o     (mdu_b),
        .mdu_result_i(mdu_result),
        .mdu_ready_i (mdu_ready),
        .stall_o     (stall),
        .busy_o      (busy),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    always #5 clk = ~clk;

    // Arithmetic MDU: {HI,LO} = product, or {remainder, quotient}.
    function automatic logic [63:0] mduModel(input logic [4:0] code, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] q;
        logic signed [63:0] r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (code)
            C_MULT:  return sx * sy;
            C_MULTU: return {32'd0, x} * {32'd0, y};
            C_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            C_DIVU: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'h0BAD_0BAD_0BAD_0BAD;
        endcase
    endfunction

    function automatic logic [4:0] opCode(input logic [2:0] o);
        case (o)
            3'd1:    return C_MULT;
            3'd2:    return C_MULTU;
            3'd3:    return C_DIV;
            3'd4:    return C_DIVU;
            default: return C_NONE;
        endcase
    endfunction

    always_comb mdu_result = mduModel(mdu_ctrl, mdu_a, mdu_b);

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic driveIdle();
        op_valid  = 1'b0;
        op        = 3'd0;
        flush     = 1'b0;
        mdu_ready = 1'b0;
        a         = $urandom;
        b         = $urandom;
    endtask

    task automatic checkHiLo(input string tag);
        checkOutput({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        checkOutput({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    // MTHI / MTLO, optionally under flush (which must suppress the write).
    task automatic applyMove(input logic [2:0] mop, input logic [31:0] val, input logic fl);
        op_valid = 1'b1;
        op       = mop;
        a        = val;
        flush    = fl;
        #1;
        checkOutput("mv_stall", {63'd0, stall}, 64'd0);
        nextCycle();
        if (!fl && mop == 3'd5) exp_hi = val;
        if (!fl && mop == 3'd6) exp_lo = val;
        driveIdle();
        #1;
        checkOutput("mv_busy", {63'd0, busy}, 64'd0);
        checkHiLo("mv");
    endtask

    // Instruction with no effect: op none/7, or a multiply killed by flush.
    task automatic applyNop(input logic [2:0] nop, input logic fl);
        op_valid = 1'b1;
        op       = nop;
        flush    = fl;
        #1;
        checkOutput("nop_stall", {63'd0, stall}, 64'd0);
        nextCycle();
        driveIdle();
        #1;
        checkOutput("nop_busy", {63'd0, busy}, 64'd0);
        checkOutput("nop_ctrl", {59'd0, mdu_ctrl}, {59'd0, C_NONE});
        checkHiLo("nop");
    endtask

    // One MULT/MULTU/DIV/DIVU transaction. lat = cycle after issue on which
    // the divider reports ready; flush_at = cycle after issue carrying flush
    // (0 = never); rdy_on_flush raises ready together with the flush.
    task automatic applyStimulus(input logic [2:0] mop, input logic [31:0] va, input logic [31:0] vb,
                                 input int lat, input int flush_at, input logic rdy_on_flush);
        logic [63:0] res;
        logic        flushed;
        logic        done;
        logic        is_mul;
        is_mul  = (mop == 3'd1) || (mop == 3'd2);
        res     = mduModel(opCode(mop), va, vb);
        flushed = 1'b0;
        done    = 1'b0;
        op_valid = 1'b1;
        op       = mop;
        a        = va;
        b        = vb;
        flush    = 1'b0;
        #1;
        checkOutput("iss_stall", {63'd0, stall}, 64'd1);
        checkOutput("iss_busy", {63'd0, busy}, 64'd0);
        nextCycle();
        driveIdle();
        for (int k = 1; k <= (is_mul ? 1 : lat) && !done; k++) begin
            flush     = (k == flush_at);
            mdu_ready = is_mul ? 1'($urandom_range(0, 1)) : ((k == lat) || (flush && rdy_on_flush));
            a         = $urandom;
            b         = $urandom;
            #1;
            checkOutput("wait_busy", {63'd0, busy}, 64'd1);
            checkOutput("wait_ctrl", {59'd0, mdu_ctrl}, {59'd0, opCode(mop)});
            checkOutput("wait_a", {32'd0, mdu_a}, {32'd0, va});
            checkOutput("wait_b", {32'd0, mdu_b}, {32'd0, vb});
            checkOutput("wait_stall", {63'd0, stall},
                        {63'd0, !is_mul && !flush && !mdu_ready});
            if (flush) begin
                flushed = 1'b1;
                done    = 1'b1;
            end else if (is_mul || mdu_ready) begin
                exp_hi = res[63:32];
                exp_lo = res[31:0];
                done   = 1'b1;
            end
            nextCycle();
            driveIdle();
        end
        if (flushed) begin
            // Flush cycle: a multiply offered here must be ignored.
            op_valid = 1'b1;
            op       = 3'd1;
            #1;
            checkOutput("fl_busy", {63'd0, busy}, 64'd1);
            checkOutput("fl_ctrl", {59'd0, mdu_ctrl}, {59'd0, C_NONE});
            checkOutput("fl_stall", {63'd0, stall}, 64'd0);
            checkHiLo("fl");
            nextCycle();
            driveIdle();
        end
        #1;
        checkOutput("end_busy", {63'd0, busy}, 64'd0);
        checkOutput("end_ctrl", {59'd0, mdu_ctrl}, {59'd0, C_NONE});
        checkOutput("end_a", {32'd0, mdu_a}, {32'd0, va});
        checkHiLo("end");
    endtask

    initial begin
        int kind;
        int lat;
        int fat;
        logic [2:0] mop;
        driveIdle();
        rst = 1'b1;
        nextCycle();
        nextCycle();
        rst = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        #1;
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkHiLo("rst");

        // Signed multiply of -2 by 3.
        applyStimulus(3'd1, 32'hFFFF_FFFE, 32'd3, 1, 0, 1'b0);
        checkOutput("mult_hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        checkOutput("mult_lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);

        // Unsigned divide 100/7 with 33-cycle latency.
        applyStimulus(3'd4, 32'd100, 32'd7, 33, 0, 1'b0);
        checkOutput("divu_hi_const", {32'd0, hi}, 64'd2);
        checkOutput("divu_lo_const", {32'd0, lo}, 64'd14);

        // Divide flushed on cycle 10, then multiply accepted after FLUSH.
        applyStimulus(3'd3, 32'd1000, 32'd3, 33, 10, 1'b0);
        applyStimulus(3'd2, 32'd5, 32'd6, 1, 0, 1'b0);
        // Flush and ready in the same divide cycle.
        applyStimulus(3'd3, 32'hFFFF_FF00, 32'd9, 5, 5, 1'b1);
        // Flush of a multiply.
        applyStimulus(3'd1, 32'd77, 32'd88, 1, 1, 1'b0);

        // Moves back to back, and a flushed move.
        applyMove(3'd5, 32'h1234_5678, 1'b0);
        applyMove(3'd6, 32'h9ABC_DEF0, 1'b0);
        checkOutput("mthi_const", {32'd0, hi}, 64'h1234_5678);
        checkOutput("mtlo_const", {32'd0, lo}, 64'h9ABC_DEF0);
        applyMove(3'd5, 32'hDEAD_BEEF, 1'b1);
        applyNop(3'd7, 1'b0);
        applyNop(3'd1, 1'b1);

        // Division by zero passes straight through.
        applyStimulus(3'd4, 32'd42, 32'd0, 3, 0, 1'b0);

        // Reset held two cycles in the middle of a divide.
        op_valid = 1'b1;
        op       = 3'd3;
        a        = 32'd500;
        b        = 32'd4;
        nextCycle();
        driveIdle();
        nextCycle();
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("rstd_stall", {63'd0, stall}, 64'd0);
        checkOutput("rstd_ctrl", {59'd0, mdu_ctrl}, {59'd0, C_NONE});
        nextCycle();
        nextCycle();
        rst = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        #1;
        checkOutput("rsta_busy", {63'd0, busy}, 64'd0);
        checkOutput("rsta_stall", {63'd0, stall}, 64'd0);
        checkOutput("rsta_ctrl", {59'd0, mdu_ctrl}, {59'd0, C_NONE});
        checkOutput("rsta_a", {32'd0, mdu_a}, 64'd0);
        checkHiLo("rsta");

        // Randomized mix.
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 1) begin
                applyMove(3'($urandom_range(5, 6)), $urandom, ($urandom_range(0, 7) == 0));
            end else if (kind == 2) begin
                applyNop(($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7, 1'b0);
            end else if (kind == 3) begin
                applyNop(3'($urandom_range(1, 4)), 1'b1);
            end else begin
                mop = 3'($urandom_range(1, 4));
                lat = (mop <= 3'd2) ? 1 : $urandom_range(1, 12);
                fat = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
                applyStimulus(mop, $urandom, ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom,
                              lat, fat, 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_hilo_ctrl.md
Name: mdu_hilo_ctrl

Overview:
Sequencer between the EX stage and the multiply/divide unit. It accepts one MDU-class instruction at a time and latches its operands. It drives the unit's 5-bit control code until the result is ready, stalls the pipeline meanwhile, and commits the 64-bit result into the architectural HI/LO registers. It also executes MTHI/MTLO and discards in-flight work on an exception flush.

Parameters:
CODE_NONE, 5'd0, control code meaning "no operation" (divider idle)
CODE_MULT, 5'd1, signed-multiply control code; overridden at instantiation with the global control define
CODE_MULTU, 5'd2, unsigned-multiply control code; overridden likewise
CODE_DIV, 5'd3, signed-divide control code; overridden likewise
CODE_DIVU, 5'd4, unsigned-divide control code; overridden likewise

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
op_valid_i  in  1  EX stage holds an MDU-class instruction
op_i  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 treated as none
a_i  in  32  rs operand (MTHI/MTLO source)
b_i  in  32  rt operand
flush_i  in  1  exception/eret flush of EX and older stages
mdu_ctrl_o  out  5  control code to the MDU
mdu_a_o  out  32  latched operand A to the MDU
mdu_b_o  out  32  latched operand B to the MDU
mdu_result_i  in  64  MDU result; {HI, LO}
mdu_ready_i  in  1  MDU result valid (level)
stall_o  out  1  combinational; freeze IF..EX this cycle
busy_o  out  1  FSM not in IDLE
hi_o  out  32  HI register
lo_o  out  32  LO register

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; hi_o=lo_o=0; operand latches=0. Outputs during and after reset: mdu_ctrl_o=CODE_NONE, stall_o=0, busy_o=0.
- States: IDLE, MUL, DIV, FLUSH. mdu_ctrl_o is registered-state-derived:
  - IDLE and FLUSH: CODE_NONE.
  - MUL: latched mult code.
  - DIV: latched div code.
- IDLE:
  - flush_i=1: no action, stay IDLE.
  - op_valid_i & op MULT/MULTU: latch a_i, b_i and op; go MUL; stall_o=1 this cycle.
  - op_valid_i & op DIV/DIVU: latch operands and op; go DIV; stall_o=1.
  - op_valid_i & op MTHI: hi_o<=a_i at edge; no stall. MTLO: lo_o<=a_i likewise.
  - op none/7: nothing.
- MUL: stall_o=0. At the edge: {hi_o,lo_o}<=mdu_result_i, go IDLE. The multiply is single-cycle combinational in the MDU, so mdu_ready_i is ignored. Total: 1 stall cycle; HI/LO visible 2 cycles after issue.
- DIV: stall_o=!mdu_ready_i.
  - When mdu_ready_i=1: commit {hi_o,lo_o}<=mdu_result_i, go IDLE.
  - Otherwise hold state; mdu_a_o, mdu_b_o and mdu_ctrl_o stay constant regardless of a_i/b_i changes.
- FLUSH: one cycle with CODE_NONE so the divider returns to idle. stall_o=0; new ops ignored; then go IDLE.
- flush_i in MUL or DIV: no HI/LO write even if mdu_ready_i=1 that cycle; go FLUSH; stall_o=0 that cycle. Flush has priority over every other event.
- mdu_a_o/mdu_b_o always drive the latches; in IDLE they hold the last issued values.
- No back-to-back issue: the MDU instruction that follows a MUL/DIV is sampled only once the FSM is back in IDLE.
- busy_o=1 in MUL, DIV and FLUSH.
- Division by zero is passed to the MDU unchanged; the commit happens whenever the MDU raises ready.
- MFHI/MFLO read hi_o/lo_o directly; the pipeline stall guarantees no read of a pending result.

Test Plan:
- Reset: hold rst 2 cycles mid-DIV -> hi_o=lo_o=0, mdu_ctrl_o=CODE_NONE, stall_o=0, busy_o=0 next cycle.
- MULT a=0xFFFFFFFE (-2), b=3, MDU model returns 0xFFFFFFFF_FFFFFFFA -> stall_o high exactly 1 cycle; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA one edge later.
- DIVU a=100, b=7, model ready after 33 cycles, result {2,14} -> stall_o high 33 cycles, low on ready cycle; hi_o=2, lo_o=14. Toggle a_i during wait: mdu_a_o stays 100.
- DIV with flush_i pulsed on cycle 10 -> no HI/LO change; one FLUSH cycle with CODE_NONE; a MULT issued on the FLUSH cycle is ignored, accepted next cycle.
- flush_i and mdu_ready_i asserted in the same DIV cycle -> HI/LO unchanged, state FLUSH.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles, no stall -> hi_o/lo_o updated one edge after each; flush_i with MTHI in IDLE -> no write.
